// File: rtl/switch_debouncer.sv
// Switch debouncer for 16 slide switches.
// Each raw switch bit is synchronised and sampled once per divider tick.
// A per-bit agree counter accepts the new level after STABLE_SAMPLES
// consecutive disagreeing samples. Accepted changes produce a one-cycle
// toggle pulse while enable_i is high, and that pulse is summarised as
// any / lowest index / multiple.
module switch_debouncer #(
   parameter int unsigned SAMPLE_DIV     = 100000,
   parameter int unsigned STABLE_SAMPLES = 4
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic [15:0] switches_i,
   output logic [15:0] switches_db_o,
   output logic [15:0] toggle_pulse_o,
   output logic        any_toggle_o,
   output logic [3:0]  toggle_index_o,
   output logic        multi_toggle_o
);

   localparam int unsigned     DIV_W      = $clog2(SAMPLE_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [3:0]      STABLE_CNT = 4'(STABLE_SAMPLES);

   typedef enum logic {
      UNPRIMED = 1'b0,
      PRIMED   = 1'b1
   } prime_state_t;

   logic [15:0]      sync_meta;
   logic [15:0]      sync;
   logic [DIV_W-1:0] div_count;
   logic             tick;
   prime_state_t     state;
   logic [3:0]       agree [16];
   logic [15:0]      db;
   logic [15:0]      pulse;

   // Two-flop synchroniser on every raw switch bit.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         sync_meta <= '0;
         sync      <= '0;
      end else begin
         sync_meta <= switches_i;
         sync      <= sync_meta;
      end
   end

   // Free-running sample divider, wrapping after SAMPLE_DIV-1.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         div_count <= '0;
      end else if (tick) begin
         div_count <= '0;
      end else begin
         div_count <= div_count + 1'b1;
      end
   end

   // Sample tick is high for the single cycle the divider sits at its last value.
   always_comb begin
      tick = (div_count == DIV_LAST);
   end

   // Priming, per-bit agreement counting, level acceptance and pulse generation.
   // The first tick after reset only loads the debounced level; later ticks
   // count disagreeing samples and flip the level when the count completes.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state <= UNPRIMED;
         db    <= '0;
         pulse <= '0;
         for (int unsigned k = 0; k < 16; k++) begin
            agree[k] <= '0;
         end
      end else begin
         pulse <= '0;
         if (tick) begin
            if (state == UNPRIMED) begin
               db    <= sync;
               state <= PRIMED;
               for (int unsigned k = 0; k < 16; k++) begin
                  agree[k] <= '0;
               end
            end else begin
               for (int unsigned k = 0; k < 16; k++) begin
                  if (sync[k] != db[k]) begin
                     // Acceptance happens on the edge where the count would
                     // reach STABLE_SAMPLES, so the stored count never exceeds it.
                     if ((agree[k] + 4'd1) >= STABLE_CNT) begin
                        db[k]    <= ~db[k];
                        agree[k] <= '0;
                        pulse[k] <= enable_i;
                     end else begin
                        agree[k] <= agree[k] + 4'd1;
                     end
                  end else begin
                     agree[k] <= '0;
                  end
               end
            end
         end
      end
   end

   // Summary of the registered pulse vector: any, multiple, lowest set index.
   always_comb begin
      any_toggle_o   = |pulse;
      multi_toggle_o = |(pulse & (pulse - 16'd1));
      toggle_index_o = '0;
      for (int unsigned k = 16; k > 0; k--) begin
         if (pulse[k-1]) begin
            toggle_index_o = 4'(k - 1);
         end
      end
   end

   assign switches_db_o  = db;
   assign toggle_pulse_o = pulse;

endmodule

// File: tb/tb_switch_debouncer.sv
// Table-driven bench for switch_debouncer with SAMPLE_DIV=4, STABLE_SAMPLES=3.
// Each record holds inputs for a run of cycles; the pulse must stay zero on
// every cycle but the last, where all outputs are compared.
module tb_switch_debouncer;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] sw;
   logic [15:0] db;
   logic [15:0] pulse;
   logic        any_t;
   logic [3:0]  idx;
   logic        multi;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   typedef struct {
      logic        rst;
      logic        en;
      logic [15:0] sw;
      int unsigned ncyc;
      logic [15:0] db;
      logic [15:0] pulse;
      logic        any_t;
      logic [3:0]  idx;
      logic        multi;
   } vec_t;

   vec_t tbl[$];

   switch_debouncer #(
      .SAMPLE_DIV(4),
      .STABLE_SAMPLES(3)
   ) dut (
      .clock_i(clk),
      .reset_i(rst),
      .enable_i(en),
      .switches_i(sw),
      .switches_db_o(db),
      .toggle_pulse_o(pulse),
      .any_toggle_o(any_t),
      .toggle_index_o(idx),
      .multi_toggle_o(multi)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s vec=%0d got=%h expected=%h", name, id, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic e, input logic [15:0] s, input int unsigned n,
                      input logic [15:0] d, input logic [15:0] p, input logic a,
                      input logic [3:0] i, input logic m);
      vec_t v;
      v.rst = r; v.en = e; v.sw = s; v.ncyc = n;
      v.db = d; v.pulse = p; v.any_t = a; v.idx = i; v.multi = m;
      tbl.push_back(v);
   endtask

   task automatic run_vec(input vec_t v, input int id);
      for (int unsigned c = 0; c < v.ncyc; c++) begin
         rst = v.rst;
         en  = v.en;
         sw  = v.sw;
         @(posedge clk);
         #1;
         if (c + 1 < v.ncyc) begin
            chk("pulse_idle", id, pulse, 16'h0000);
         end else begin
            chk("db", id, db, v.db);
            chk("pulse", id, pulse, v.pulse);
            chk("any", id, {15'd0, any_t}, {15'd0, v.any_t});
            chk("index", id, {12'd0, idx}, {12'd0, v.idx});
            chk("multi", id, {15'd0, multi}, {15'd0, v.multi});
         end
      end
   endtask

   task automatic reset_and_prime(input logic e, input logic [15:0] s);
      add(1'b1, e, s, 1, 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, e, s, 4, s,        16'h0000, 1'b0, 4'd0, 1'b0);
   endtask

   initial begin
      vec_t hv;
      rst = 1'b1;
      en  = 1'b1;
      sw  = 16'h0000;

      // Priming loads the held input, no pulse.
      add(1'b1, 1'b1, 16'h0005, 1, 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, 1'b1, 16'h0005, 3, 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, 1'b1, 16'h0005, 1, 16'h0005, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, 1'b1, 16'h0005, 8, 16'h0005, 16'h0000, 1'b0, 4'd0, 1'b0);

      // Clean rise on bit 3, then clean fall.
      reset_and_prime(1'b1, 16'h0000);
      add(1'b0, 1'b1, 16'h0008, 11, 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, 1'b1, 16'h0008, 1,  16'h0008, 16'h0008, 1'b1, 4'd3, 1'b0);
      add(1'b0, 1'b1, 16'h0008, 1,  16'h0008, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, 1'b1, 16'h0000, 10, 16'h0008, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, 1'b1, 16'h0000, 1,  16'h0000, 16'h0008, 1'b1, 4'd3, 1'b0);

      // Bounce: two agreeing ticks then release; the count must restart.
      reset_and_prime(1'b1, 16'h0000);
      add(1'b0, 1'b1, 16'h0008, 8,  16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, 1'b1, 16'h0000, 12, 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, 1'b1, 16'h0008, 8,  16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, 1'b1, 16'h0008, 4,  16'h0008, 16'h0008, 1'b1, 4'd3, 1'b0);

      // Simultaneous acceptance of bits 2 and 9.
      reset_and_prime(1'b1, 16'h0000);
      add(1'b0, 1'b1, 16'h0204, 12, 16'h0204, 16'h0204, 1'b1, 4'd2, 1'b1);
      add(1'b0, 1'b1, 16'h0204, 1,  16'h0204, 16'h0000, 1'b0, 4'd0, 1'b0);

      // High bits 12 and 15 together.
      reset_and_prime(1'b1, 16'h0000);
      add(1'b0, 1'b1, 16'h9000, 12, 16'h9000, 16'h9000, 1'b1, 4'd12, 1'b1);

      // Enable low: level tracks, no pulses, none replayed on enable.
      reset_and_prime(1'b0, 16'h0000);
      add(1'b0, 1'b0, 16'h0020, 12, 16'h0020, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, 1'b0, 16'h0000, 12, 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, 1'b1, 16'h0000, 8,  16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0);

      // Reset after two agreeing ticks discards the agreement; re-prime.
      reset_and_prime(1'b1, 16'h0000);
      add(1'b0, 1'b1, 16'h0040, 8,  16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b1, 1'b1, 16'h0040, 1,  16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, 1'b1, 16'h0040, 3,  16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, 1'b1, 16'h0040, 1,  16'h0040, 16'h0000, 1'b0, 4'd0, 1'b0);
      add(1'b0, 1'b1, 16'h0040, 12, 16'h0040, 16'h0000, 1'b0, 4'd0, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         run_vec(tbl[i], i);
      end

      // Hand sequence: reset lands on the edge that would accept bit 3,
      // so the pending pulse must never appear.
      hv = '{rst:1'b1, en:1'b1, sw:16'h0000, ncyc:1, db:16'h0000, pulse:16'h0000, any_t:1'b0, idx:4'd0, multi:1'b0};
      run_vec(hv, 100);
      hv = '{rst:1'b0, en:1'b1, sw:16'h0000, ncyc:4, db:16'h0000, pulse:16'h0000, any_t:1'b0, idx:4'd0, multi:1'b0};
      run_vec(hv, 101);
      hv = '{rst:1'b0, en:1'b1, sw:16'h0008, ncyc:11, db:16'h0000, pulse:16'h0000, any_t:1'b0, idx:4'd0, multi:1'b0};
      run_vec(hv, 102);
      hv = '{rst:1'b1, en:1'b1, sw:16'h0008, ncyc:1, db:16'h0000, pulse:16'h0000, any_t:1'b0, idx:4'd0, multi:1'b0};
      run_vec(hv, 103);
      hv = '{rst:1'b0, en:1'b1, sw:16'h0008, ncyc:3, db:16'h0000, pulse:16'h0000, any_t:1'b0, idx:4'd0, multi:1'b0};
      run_vec(hv, 104);
      hv = '{rst:1'b0, en:1'b1, sw:16'h0008, ncyc:1, db:16'h0008, pulse:16'h0000, any_t:1'b0, idx:4'd0, multi:1'b0};
      run_vec(hv, 105);
      hv = '{rst:1'b0, en:1'b1, sw:16'h0008, ncyc:12, db:16'h0008, pulse:16'h0000, any_t:1'b0, idx:4'd0, multi:1'b0};
      run_vec(hv, 106);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
